// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, ALU op / control
// types, issue FSM states and the immediate generator.
package alu_issue_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_t;

  // a: operand A comes from rs1; sign: SUB / SRA variant
  typedef struct packed {
    logic a;
    logic sign;
  } control_signals_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } issue_state_t;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_U    = 2'd2
  } imm_sel_t;

  // Build the immediate from instr[31:12]
  function automatic logic [XLEN-1:0] gen_imm(input logic [19:0] upper,
                                               input imm_sel_t sel);
    logic [XLEN-1:0] imm;
    case (sel)
      IMM_I:   imm = {{20{upper[19]}}, upper[19:8]};
      IMM_U:   imm = {upper, 12'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// ALU request bus between the issue stage (master) and EX (slave).
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic             ex_valid;
  logic             ex_ready;
  logic [2:0]       ex_func3;
  control_signals_t ex_cs;
  logic [XLEN-1:0]  ex_alu_a;
  logic [XLEN-1:0]  ex_alu_b;
  logic [4:0]       ex_rd;
  logic             ex_rd_we;

  modport master (
    output ex_valid, ex_func3, ex_cs, ex_alu_a, ex_alu_b, ex_rd, ex_rd_we,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_func3, ex_cs, ex_alu_a, ex_alu_b, ex_rd, ex_rd_we,
    output ex_ready
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode for OP, OP-IMM, LUI and AUIPC.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  output alu_op_t          func3,
  output control_signals_t cs,
  output logic [XLEN-1:0]  imm,
  output logic             b_imm,
  output logic [XLEN-1:0]  a_base,
  output logic             uses_rs1,
  output logic             uses_rs2,
  output logic             rd_we,
  output logic             illegal
);

  imm_sel_t imm_sel;

  // Opcode decode; a_base is operand A when cs.a=0 (LUI: 0, AUIPC: pc)
  always_comb begin
    func3    = ALU_ADD;
    cs       = '0;
    imm_sel  = IMM_NONE;
    a_base   = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        cs.a     = 1'b1;
        func3    = alu_op_t'(instr[14:12]);
        cs.sign  = instr[30] && (instr[14:12] == 3'b000 || instr[14:12] == 3'b101);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        cs.a     = 1'b1;
        func3    = alu_op_t'(instr[14:12]);
        cs.sign  = instr[30] && (instr[14:12] == 3'b101);
        imm_sel  = IMM_I;
        uses_rs1 = 1'b1;
      end
      OPC_LUI: begin
        imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        imm_sel = IMM_U;
        a_base  = pc;
      end
      default: illegal = 1'b1;
    endcase
    imm   = gen_imm(instr[31:12], imm_sel);
    b_imm = (imm_sel != IMM_NONE);
    rd_we = !illegal && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode, regfile read with writeback forwarding,
// pending-destination scoreboard, RUN/TRAP FSM and a registered ALU request.
// Optional macro ALU_ISSUE_PERF_EN adds perf_issued / perf_stall counters.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  instr_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  alu_issue_if.master      ex,
  output logic             illegal,
  input  logic             illegal_clear
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`endif
);

  alu_op_t          dec_func3;
  control_signals_t dec_cs;
  logic [XLEN-1:0]  dec_imm, dec_a_base;
  logic             dec_b_imm, dec_uses_rs1, dec_uses_rs2, dec_rd_we, dec_illegal;

  issue_state_t     state_q, state_d;
  logic [NREG-1:0]  pending_q, pending_d;
  logic [4:0]       rd;
  logic             fwd1, fwd2, hazard, slot_free, accept, issue;
  logic [XLEN-1:0]  rs1_val, rs2_val;

  alu_issue_decode u_decode (
    .instr    (instr),
    .pc       (instr_pc),
    .func3    (dec_func3),
    .cs       (dec_cs),
    .imm      (dec_imm),
    .b_imm    (dec_b_imm),
    .a_base   (dec_a_base),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .rd_we    (dec_rd_we),
    .illegal  (dec_illegal)
  );

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd       = instr[11:7];

  // Operand select: x0, then same-cycle writeback, then regfile
  always_comb begin
    fwd1    = wb_valid && (wb_rd == rs1_addr);
    fwd2    = wb_valid && (wb_rd == rs2_addr);
    rs1_val = (rs1_addr == 5'd0) ? '0 : (fwd1 ? wb_data : rs1_data);
    rs2_val = (rs2_addr == 5'd0) ? '0 : (fwd2 ? wb_data : rs2_data);
  end

  // Stall on unforwarded pending sources (RAW) or a pending destination (WAW)
  always_comb begin
    hazard = (dec_uses_rs1 && rs1_addr != 5'd0 && pending_q[rs1_addr] && !fwd1) ||
             (dec_uses_rs2 && rs2_addr != 5'd0 && pending_q[rs2_addr] && !fwd2) ||
             (dec_rd_we && pending_q[rd]);
    slot_free   = !ex.ex_valid || ex.ex_ready;
    instr_ready = (state_q == RUN) && slot_free && !hazard;
    accept      = instr_valid && instr_ready;
    issue       = accept && !dec_illegal;
  end

  assign illegal = (state_q == TRAP);

  // FSM next state: an accepted illegal opcode traps until illegal_clear
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && dec_illegal) state_d = TRAP;
      TRAP:    if (illegal_clear) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Scoreboard update; the set is applied after the clear so it wins
  always_comb begin
    pending_d = pending_q;
    if (wb_valid) pending_d[wb_rd] = 1'b0;
    if (issue && dec_rd_we) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // ALU request register: load on issue, drop valid when consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      ex.ex_valid <= 1'b0;
      ex.ex_func3 <= '0;
      ex.ex_cs    <= '0;
      ex.ex_alu_a <= '0;
      ex.ex_alu_b <= '0;
      ex.ex_rd    <= '0;
      ex.ex_rd_we <= 1'b0;
    end else if (issue) begin
      ex.ex_valid <= 1'b1;
      ex.ex_func3 <= dec_func3;
      ex.ex_cs    <= dec_cs;
      ex.ex_alu_a <= dec_cs.a ? rs1_val : dec_a_base;
      ex.ex_alu_b <= dec_b_imm ? dec_imm : rs2_val;
      ex.ex_rd    <= rd;
      ex.ex_rd_we <= dec_rd_we;
    end else if (ex.ex_ready) begin
      ex.ex_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // Accept and RUN-state stall counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept) perf_issued <= perf_issued + 32'd1;
      if (instr_valid && state_q == RUN && !instr_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: expected ALU requests are queued when
// an instruction is accepted and compared when EX consumes a request.
module tb_alu_issue;
  import alu_issue_pkg::*;

  typedef struct packed {
    logic [2:0]  f3;
    logic [1:0]  cs;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, instr_valid, instr_ready, wb_valid, illegal, illegal_clear;
  logic [31:0] instr, instr_pc, rs1_data, rs2_data, wb_data;
  logic [4:0]  rs1_addr, rs2_addr, wb_rd;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif
  logic [31:0] rf [32];
  logic [19:0] lui_imm;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t got_e;

  always #5 clk = ~clk;

  alu_issue_if ex_bus ();

  alu_issue dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .ex            (ex_bus),
    .illegal       (illegal),
    .illegal_clear (illegal_clear)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_stall    (perf_stall)
`endif
  );

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] f3, input logic [1:0] cs,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic we);
    exp_t e;
    e.f3 = f3; e.cs = cs; e.a = a; e.b = b; e.rd = rd; e.we = we;
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Consumer side: compare each request EX takes against the queue head
  always @(negedge clk) begin
    if (!rst && ex_bus.ex_valid && ex_bus.ex_ready) begin
      if (sb.size() == 0) begin
        check_eq("ex_unexpected", {31'b0, ex_bus.ex_valid}, 32'd0);
      end else begin
        got_e = sb.pop_front();
        check_eq("ex_func3", {29'b0, ex_bus.ex_func3}, {29'b0, got_e.f3});
        check_eq("ex_cs",    {30'b0, ex_bus.ex_cs},    {30'b0, got_e.cs});
        check_eq("ex_alu_a", ex_bus.ex_alu_a, got_e.a);
        check_eq("ex_alu_b", ex_bus.ex_alu_b, got_e.b);
        check_eq("ex_rd",    {27'b0, ex_bus.ex_rd},    {27'b0, got_e.rd});
        check_eq("ex_rd_we", {31'b0, ex_bus.ex_rd_we}, {31'b0, got_e.we});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] pc);
    instr       = i;
    instr_pc    = pc;
    instr_valid = 1'b1;
  endtask

  task automatic wait_accept(input exp_t e, input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    check_eq({tag, "_accept"}, {31'b0, done}, 32'd1);
    @(negedge clk);
    if (done) check_eq({tag, "_latency"}, {31'b0, ex_bus.ex_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wb_cycle(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = d;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    if (rd != 5'd0) rf[rd] = d;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ex_valid"}, {31'b0, ex_bus.ex_valid}, 32'd0);
    check_eq({tag, "_ex_func3"}, {29'b0, ex_bus.ex_func3}, 32'd0);
    check_eq({tag, "_ex_cs"},    {30'b0, ex_bus.ex_cs},    32'd0);
    check_eq({tag, "_ex_alu_a"}, ex_bus.ex_alu_a, 32'd0);
    check_eq({tag, "_ex_alu_b"}, ex_bus.ex_alu_b, 32'd0);
    check_eq({tag, "_ex_rd"},    {27'b0, ex_bus.ex_rd},    32'd0);
    check_eq({tag, "_ex_rd_we"}, {31'b0, ex_bus.ex_rd_we}, 32'd0);
    check_eq({tag, "_illegal"},  {31'b0, illegal},         32'd0);
    check_eq({tag, "_ready"},    {31'b0, instr_ready},     32'd1);
`ifdef ALU_ISSUE_PERF_EN
    check_eq({tag, "_perf_issued"}, perf_issued, 32'd0);
    check_eq({tag, "_perf_stall"},  perf_stall,  32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; instr_pc = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; illegal_clear = 1'b0;
    ex_bus.ex_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;

    do_reset();
    check_reset_state("rst");

    // Basic ALU forms
    offer(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0);
    wait_accept(mk(3'b000, 2'b10, 32'd5, 32'd7, 5'd3, 1'b1), "add", 1);
    offer(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4), 32'h4);
    wait_accept(mk(3'b000, 2'b11, 32'd5, 32'd7, 5'd4, 1'b1), "sub", 1);
    offer(enc_i(12'h404, 5'd1, 3'b101, 5'd5), 32'h8);
    wait_accept(mk(3'b101, 2'b11, 32'd5, 32'h404, 5'd5, 1'b1), "srai", 1);
    offer(enc_i(12'hFFF, 5'd0, 3'b000, 5'd6), 32'hC);
    wait_accept(mk(3'b000, 2'b10, 32'd0, 32'hFFFFFFFF, 5'd6, 1'b1), "addi", 1);
    wb_cycle(5'd4, 32'h44);
    wb_cycle(5'd5, 32'h55);
    wb_cycle(5'd6, 32'h66);

    // RAW on pending x3, released by a forwarded writeback
    offer(enc_r(7'b0000000, 5'd3, 5'd3, 3'b000, 5'd7), 32'h10);
    repeat (2) begin
      @(negedge clk);
      check_eq("raw_stall", {31'b0, instr_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
`ifdef ALU_ISSUE_PERF_EN
    check_eq("perf_stall_raw", perf_stall, 32'd2);
    check_eq("perf_issued_raw", perf_issued, 32'd4);
`endif
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    wait_accept(mk(3'b000, 2'b10, 32'hDEAD, 32'hDEAD, 5'd7, 1'b1), "raw_fwd", 1);
    wb_valid = 1'b0; rf[3] = 32'hDEAD;
    wb_cycle(5'd7, 32'h77);

    // Backpressure: request held, then the next one loads on ex_ready
    ex_bus.ex_ready = 1'b0;
    offer(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd8), 32'h14);
    wait_accept(mk(3'b000, 2'b10, 32'd5, 32'd7, 5'd8, 1'b1), "bp_first", 1);
    offer(enc_i(12'd1, 5'd1, 3'b000, 5'd9), 32'h18);
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_ready", {31'b0, instr_ready}, 32'd0);
      check_eq("bp_hold_rd", {27'b0, ex_bus.ex_rd}, 32'd8);
      check_eq("bp_hold_b", ex_bus.ex_alu_b, 32'd7);
      @(posedge clk);
      #1;
    end
`ifdef ALU_ISSUE_PERF_EN
    check_eq("perf_stall_bp", perf_stall, 32'd5);
`endif
    ex_bus.ex_ready = 1'b1;
    wait_accept(mk(3'b000, 2'b10, 32'd5, 32'd1, 5'd9, 1'b1), "bp_load", 1);
    wb_cycle(5'd8, 32'h88);
    wb_cycle(5'd9, 32'h99);

    // Forwarding priority: x0 beats a writeback to x0; writeback beats regfile
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    offer(enc_r(7'b0000000, 5'd1, 5'd0, 3'b000, 5'd10), 32'h1C);
    wait_accept(mk(3'b000, 2'b10, 32'd0, 32'd5, 5'd10, 1'b1), "fwd_x0", 1);
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'd9;
    offer(enc_r(7'b0000000, 5'd1, 5'd2, 3'b000, 5'd11), 32'h20);
    wait_accept(mk(3'b000, 2'b10, 32'd9, 32'd5, 5'd11, 1'b1), "fwd_wb", 1);
    wb_valid = 1'b0; rf[2] = 32'd9;
    wb_cycle(5'd10, 32'hA0);
    wb_cycle(5'd11, 32'hB0);

    // AUIPC / LUI x0
    offer({20'h12345, 5'd1, 7'b0010111}, 32'h100);
    wait_accept(mk(3'b000, 2'b00, 32'h100, 32'h12345000, 5'd1, 1'b1), "auipc", 1);
    wb_cycle(5'd1, 32'd5);
    offer({20'hABCDE, 5'd0, 7'b0110111}, 32'h104);
    wait_accept(mk(3'b000, 2'b00, 32'd0, 32'hABCDE000, 5'd0, 1'b0), "lui_x0", 1);

    // Unused source fields naming a pending register never stall
    offer(enc_i(12'd0, 5'd1, 3'b000, 5'd13), 32'h108);
    wait_accept(mk(3'b000, 2'b10, 32'd5, 32'd0, 5'd13, 1'b1), "addi_x13", 1);
    lui_imm = {7'b0, 5'd13, 5'd13, 3'b000};
    offer({lui_imm, 5'd14, 7'b0110111}, 32'h10C);
    wait_accept(mk(3'b000, 2'b00, 32'd0, {lui_imm, 12'h000}, 5'd14, 1'b1), "lui_unused", 1);
    offer(enc_i(12'd13, 5'd1, 3'b000, 5'd16), 32'h110);
    wait_accept(mk(3'b000, 2'b10, 32'd5, 32'd13, 5'd16, 1'b1), "opimm_unused", 1);
    wb_cycle(5'd13, 32'h13);
    wb_cycle(5'd14, 32'h14);
    wb_cycle(5'd16, 32'h16);

    // WAW on x15
    offer(enc_i(12'd0, 5'd1, 3'b000, 5'd15), 32'h114);
    wait_accept(mk(3'b000, 2'b10, 32'd5, 32'd0, 5'd15, 1'b1), "waw_first", 1);
    offer(enc_i(12'd2, 5'd1, 3'b000, 5'd15), 32'h118);
    repeat (2) begin
      @(negedge clk);
      check_eq("waw_stall", {31'b0, instr_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    wb_cycle(5'd15, 32'h15);
    wait_accept(mk(3'b000, 2'b10, 32'd5, 32'd2, 5'd15, 1'b1), "waw_second", 2);
    wb_cycle(5'd15, 32'h15);

    // Illegal opcode: trap, block issue, clear
    offer(32'h0000006F, 32'h11C);
    @(negedge clk);
    check_eq("jal_ready", {31'b0, instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check_eq("trap_illegal", {31'b0, illegal}, 32'd1);
    check_eq("trap_no_issue", {31'b0, ex_bus.ex_valid}, 32'd0);
    @(posedge clk);
    #1;
    offer(enc_i(12'd3, 5'd1, 3'b000, 5'd17), 32'h120);
    repeat (2) begin
      @(negedge clk);
      check_eq("trap_ready", {31'b0, instr_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    illegal_clear = 1'b1;
    @(posedge clk);
    #1;
    illegal_clear = 1'b0;
    wait_accept(mk(3'b000, 2'b10, 32'd5, 32'd3, 5'd17, 1'b1), "trap_exit", 1);
    check_eq("trap_cleared", {31'b0, illegal}, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    check_eq("perf_stall_end", perf_stall, 32'd8);
    check_eq("perf_issued_end", perf_issued, 32'd18);
`endif
    wb_cycle(5'd17, 32'h17);

    // Reset while in TRAP
    offer(32'h0000006F, 32'h124);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check_eq("trap2_illegal", {31'b0, illegal}, 32'd1);
    do_reset();
    check_reset_state("trap_rst");

    // Reset drops a held request and clears the scoreboard
    ex_bus.ex_ready = 1'b0;
    offer(enc_i(12'd4, 5'd1, 3'b000, 5'd18), 32'h128);
    wait_accept(mk(3'b000, 2'b10, 32'd5, 32'd4, 5'd18, 1'b1), "held", 1);
    do_reset();
    sb.delete();
    check_eq("held_dropped", {31'b0, ex_bus.ex_valid}, 32'd0);
    ex_bus.ex_ready = 1'b1;
    offer(enc_r(7'b0000000, 5'd18, 5'd18, 3'b000, 5'd19), 32'h12C);
    wait_accept(mk(3'b000, 2'b10, 32'd0, 32'd0, 5'd19, 1'b1), "post_rst", 1);
    wb_cycle(5'd19, 32'h19);

    @(posedge clk);
    #1;
    check_eq("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
